// File: rtl/text_line_fetcher.sv
// Text line fetcher: for each active scanline, walks one character row of
// text RAM, looks up each glyph row in font RAM and writes 8 colour indices
// per character into the line buffer. Every output is a register so the RAM
// address ports and the line-buffer write port see clean, glitch-free values.
module text_line_fetcher #(
  parameter int COLUMNS = 80,
  parameter int ROWS    = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [7:0]  line_row,
  output logic [10:0] text_addr,
  input  logic [15:0] text_rddata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_rddata,
  output logic [9:0]  lb_addr,
  output logic [3:0]  lb_wrdata,
  output logic        lb_wren,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TADDR,
    S_TDATA,
    S_FADDR,
    S_FDATA,
    S_PIX
  } state_e;

  localparam int ROW_LIMIT = ROWS * 8;

  state_e      state_q, state_d;
  logic [2:0]  glyphRow_q, glyphRow_d;
  logic [10:0] base_q, base_d;
  logic [6:0]  col_q, col_d;
  logic [2:0]  pix_q, pix_d;
  logic [3:0]  fg_q, fg_d;
  logic [3:0]  bg_q, bg_d;
  logic [7:0]  shift_q, shift_d;
  logic [10:0] textAddr_q, textAddr_d;
  logic [10:0] fontAddr_q, fontAddr_d;
  logic [9:0]  lbAddr_q, lbAddr_d;
  logic [3:0]  lbData_q, lbData_d;
  logic        lbWren_q, lbWren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [10:0] lineBase;
  logic        rowValid;
  logic        lastCol;
  logic [6:0]  colNext;

  assign lineBase = 11'(line_row[7:3]) * 11'(COLUMNS);
  assign rowValid = ({24'd0, line_row} < 32'(ROW_LIMIT));
  assign lastCol  = (col_q == 7'(COLUMNS - 1));
  assign colNext  = col_q + 7'd1;

  assign text_addr = textAddr_q;
  assign font_addr = fontAddr_q;
  assign lb_addr   = lbAddr_q;
  assign lb_wrdata = lbData_q;
  assign lb_wren   = lbWren_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state logic: sequences TADDR/TDATA/FADDR/FDATA then 8 pixel writes per
  // character; a line_start in any state restarts (or cancels) the line.
  always_comb begin
    state_d    = state_q;
    glyphRow_d = glyphRow_q;
    base_d     = base_q;
    col_d      = col_q;
    pix_d      = pix_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    shift_d    = shift_q;
    textAddr_d = textAddr_q;
    fontAddr_d = fontAddr_q;
    lbAddr_d   = lbAddr_q;
    lbData_d   = lbData_q;
    lbWren_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_TADDR: begin
        state_d = S_TDATA;
      end
      S_TDATA: begin
        fg_d       = text_rddata[11:8];
        bg_d       = text_rddata[15:12];
        fontAddr_d = {text_rddata[7:0], glyphRow_q};
        state_d    = S_FADDR;
      end
      S_FADDR: begin
        state_d = S_FDATA;
      end
      S_FDATA: begin
        shift_d  = {font_rddata[6:0], 1'b0};
        lbData_d = font_rddata[7] ? fg_q : bg_q;
        lbAddr_d = {col_q, 3'b000};
        lbWren_d = 1'b1;
        pix_d    = 3'd0;
        state_d  = S_PIX;
      end
      S_PIX: begin
        if (pix_q != 3'd7) begin
          pix_d    = pix_q + 3'd1;
          shift_d  = {shift_q[6:0], 1'b0};
          lbData_d = shift_q[7] ? fg_q : bg_q;
          lbAddr_d = lbAddr_q + 10'd1;
          lbWren_d = 1'b1;
        end else if (!lastCol) begin
          col_d      = colNext;
          textAddr_d = base_q + {4'd0, colNext};
          state_d    = S_TADDR;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (line_start) begin
      lbWren_d = 1'b0;
      done_d   = 1'b0;
      lbAddr_d = lbAddr_q;
      lbData_d = lbData_q;
      shift_d  = shift_q;
      pix_d    = 3'd0;
      if (rowValid) begin
        glyphRow_d = line_row[2:0];
        base_d     = lineBase;
        col_d      = 7'd0;
        textAddr_d = lineBase;
        state_d    = S_TADDR;
      end else begin
        state_d = S_IDLE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset drops everything to zero immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      glyphRow_q <= '0;
      base_q     <= '0;
      col_q      <= '0;
      pix_q      <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      shift_q    <= '0;
      textAddr_q <= '0;
      fontAddr_q <= '0;
      lbAddr_q   <= '0;
      lbData_q   <= '0;
      lbWren_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      glyphRow_q <= glyphRow_d;
      base_q     <= base_d;
      col_q      <= col_d;
      pix_q      <= pix_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      shift_q    <= shift_d;
      textAddr_q <= textAddr_d;
      fontAddr_q <= fontAddr_d;
      lbAddr_q   <= lbAddr_d;
      lbData_q   <= lbData_d;
      lbWren_q   <= lbWren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule
